// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StFinish,
    StDone
  } state_e;

  // Stream framing: 2-byte word-count header, then 4 bytes per word.
  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  // Little-endian byte lanes: lane 0 lands in bits [7:0].
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into little-endian 32-bit words.
// word_o is valid while word_full_o is high; the top byte comes straight from data_i
// so the completed word can be registered on the same edge that accepts byte 3.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [$clog2(WORD_BYTES)-1:0] idx_q;
  logic [23:0]                   lane_q;

  // Byte-index counter and lower-lane storage; idle cycles leave the partial word intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      lane_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      lane_q <= '0;
    end else if (valid_i) begin
      idx_q <= idx_q + 1'b1;
      unique case (idx_q)
        LANE_B0: lane_q[7:0]   <= data_i;
        LANE_B1: lane_q[15:8]  <= data_i;
        LANE_B2: lane_q[23:16] <= data_i;
        LANE_B3: ;
        default: ;
      endcase
    end
  end

  // Completed word and its one-cycle strobe.
  always_comb begin
    word_o      = {data_i, lane_q};
    word_full_o = valid_i && (idx_q == LANE_B3);
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream in, sequential
// 32-bit word writes out. Holds the core in reset until the image is committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_written
);

  // Memory depth in words, widened so a 16-bit count can be compared against it.
  localparam logic [16:0]         DEPTH  = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WW_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e      state_q;
  logic [15:0] n_q;
  logic [15:0] k_q;

  logic        accept;
  logic        data_accept;
  logic        start_ok;
  logic [15:0] n_full;
  logic [31:0] packed_word;
  logic        word_full;

  // Handshake decode and the full header count as it completes.
  always_comb begin
    accept      = byte_valid && byte_ready;
    data_accept = accept && (state_q == StData);
    start_ok    = start && ((state_q == StIdle) || (state_q == StDone));
    n_full      = {byte_data, n_q[7:0]};
  end

  word_packer u_word_packer (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (start_ok),
    .valid_i     (data_accept),
    .data_i      (byte_data),
    .word_o      (packed_word),
    .word_full_o (word_full)
  );

  // Loader FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      n_q           <= '0;
      k_q           <= '0;
      byte_ready    <= 1'b0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      core_hold     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      words_written <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we && (words_written != WW_MAX)) begin
        words_written <= words_written + 1'b1;
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StLen0;
            byte_ready    <= 1'b1;
            core_hold     <= 1'b1;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            words_written <= '0;
            n_q           <= '0;
            k_q           <= '0;
          end
        end
        StLen0: begin
          if (accept) begin
            n_q[7:0] <= byte_data;
            state_q  <= StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            n_q[15:8] <= byte_data;
            if ({1'b0, n_full} > DEPTH) begin
              load_err <= 1'b1;
            end
            if (n_full == 16'd0) begin
              state_q    <= StFinish;
              byte_ready <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (word_full) begin
            // Words beyond the memory depth are drained from the stream but not written.
            if ({1'b0, k_q} < DEPTH) begin
              imem_we    <= 1'b1;
              imem_waddr <= k_q[ADDR_WIDTH-1:0];
              imem_wdata <= packed_word;
            end
            k_q <= k_q + 16'd1;
            if (k_q == (n_q - 16'd1)) begin
              state_q    <= StFinish;
              byte_ready <= 1'b0;
            end
          end
        end
        StFinish: begin
          state_q   <= StDone;
          core_hold <= 1'b0;
          load_done <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one full-depth instance and one ADDR_WIDTH=2 instance
// share the same stimulus; each has its own expected-write queue.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic        a_byte_ready, a_imem_we, a_core_hold, a_load_done, a_load_err;
  logic [7:0]  a_imem_waddr;
  logic [31:0] a_imem_wdata;
  logic [8:0]  a_words_written;

  logic        b_byte_ready, b_imem_we, b_core_hold, b_load_done, b_load_err;
  logic [1:0]  b_imem_waddr;
  logic [31:0] b_imem_wdata;
  logic [2:0]  b_words_written;

  int total = 0;
  int bad   = 0;

  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [39:0] ea, eb;
  logic        a_prev = 1'b0;
  logic        b_prev = 1'b0;

  logic [31:0] img [8];

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(8)) dut_a (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (a_byte_ready),
    .imem_we       (a_imem_we),
    .imem_waddr    (a_imem_waddr),
    .imem_wdata    (a_imem_wdata),
    .core_hold     (a_core_hold),
    .load_done     (a_load_done),
    .load_err      (a_load_err),
    .words_written (a_words_written)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (b_byte_ready),
    .imem_we       (b_imem_we),
    .imem_waddr    (b_imem_waddr),
    .imem_wdata    (b_imem_wdata),
    .core_hold     (b_core_hold),
    .load_done     (b_load_done),
    .load_err      (b_load_err),
    .words_written (b_words_written)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (a_imem_we) begin
      chk("a_we_twice", {63'd0, a_prev}, 64'd0);
      if (qa.size() == 0) chk("a_unexpected_write", qa.size(), 1);
      else begin
        ea = qa.pop_front();
        chk("a_write", {a_imem_waddr, a_imem_wdata}, ea);
      end
    end
    if (b_imem_we) begin
      chk("b_we_twice", {63'd0, b_prev}, 64'd0);
      if (qb.size() == 0) chk("b_unexpected_write", qb.size(), 1);
      else begin
        eb = qb.pop_front();
        chk("b_write", {6'd0, b_imem_waddr, b_imem_wdata}, eb);
      end
    end
    a_prev <= a_imem_we;
    b_prev <= b_imem_we;
  end

  // Present one byte, wait for its accept edge, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int cnt = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
    while (!a_byte_ready && cnt < 50) begin
      cnt++;
      @(negedge clock);
    end
    if (!a_byte_ready) begin
      chk("ready_timeout", {63'd0, a_byte_ready}, 64'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_word(input int k, input logic [31:0] w);
    if (k < 256) qa.push_back({k[7:0], w});
    if (k < 4) qb.push_back({6'd0, k[1:0], w});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("start_ready", {63'd0, a_byte_ready}, 64'd1);
    chk("start_hold", {63'd0, a_core_hold}, 64'd1);
    chk("start_done_clr", {63'd0, a_load_done}, 64'd0);
    chk("start_err_clr", {63'd0, b_load_err}, 64'd0);
    chk("start_ww_clr", {55'd0, a_words_written}, 64'd0);
  endtask

  // Called in the cycle right after the final accept (the FINISH cycle).
  task automatic finish_checks(input int n);
    chk("a_finish_not_done", {63'd0, a_load_done}, 64'd0);
    chk("a_finish_hold", {63'd0, a_core_hold}, 64'd1);
    chk("a_finish_not_ready", {63'd0, a_byte_ready}, 64'd0);
    @(posedge clock);
    #1;
    chk("a_done", {63'd0, a_load_done}, 64'd1);
    chk("a_hold_released", {63'd0, a_core_hold}, 64'd0);
    chk("b_done", {63'd0, b_load_done}, 64'd1);
    chk("a_words_written", {55'd0, a_words_written}, (n < 256) ? n : 256);
    chk("b_words_written", {61'd0, b_words_written}, (n < 4) ? n : 4);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
  endtask

  task automatic send_image(input logic [31:0] w [8], input int n, input int gap);
    send(n[7:0], gap);
    send(n[15:8], (n == 0) ? 0 : gap);
    chk("a_load_err", {63'd0, a_load_err}, {63'd0, n > 256});
    chk("b_load_err", {63'd0, b_load_err}, {63'd0, n > 4});
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) push_word(k, w[k]);
        send(w[k][8*j +: 8], ((k == n - 1) && (j == 3)) ? 0 : gap);
      end
    end
    finish_checks(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {63'd0, a_byte_ready}, 64'd0);
    chk("rst_we", {63'd0, a_imem_we}, 64'd0);
    chk("rst_waddr", {56'd0, a_imem_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, a_imem_wdata}, 64'd0);
    chk("rst_hold", {63'd0, a_core_hold}, 64'd1);
    chk("rst_done", {63'd0, a_load_done}, 64'd0);
    chk("rst_err", {63'd0, a_load_err}, 64'd0);
    chk("rst_ww", {55'd0, a_words_written}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_not_ready", {63'd0, a_byte_ready}, 64'd0);

    // Two-word image, back-to-back.
    img = '{32'h00100513, 32'h00B505B3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_start();
    send_image(img, 2, 0);

    // Same image with 3-cycle gaps; start in DONE clears status.
    do_start();
    send_image(img, 2, 3);

    // Empty image.
    do_start();
    send_image(img, 0, 0);

    // Five words: overflows the 4-word instance only.
    img = '{32'h11223344, 32'hA5A5_5A5A, 32'h0000_0001, 32'hFFFF_FFFF, 32'hCAFE_F00D,
            32'h0, 32'h0, 32'h0};
    do_start();
    send_image(img, 5, 0);

    // Reset after 6 data bytes, then a clean one-word load.
    do_start();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int j = 0; j < 6; j++) begin
      if (j == 3) push_word(0, 32'h8877_6655);
      send(8'h55 + 8'(j * 17), 0);
    end
    reset = 1'b0;
    #1;
    chk("midrst_hold", {63'd0, a_core_hold}, 64'd1);
    chk("midrst_ready", {63'd0, a_byte_ready}, 64'd0);
    chk("midrst_ww", {55'd0, a_words_written}, 64'd0);
    chk("midrst_queue", qa.size(), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("postrst_idle_ready", {63'd0, a_byte_ready}, 64'd0);
    img = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_start();
    send_image(img, 1, 0);

    // start pulsed mid-word is ignored.
    do_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("data_start_ready", {63'd0, a_byte_ready}, 64'd1);
    chk("data_start_hold", {63'd0, a_core_hold}, 64'd1);
    push_word(0, 32'h0010_0093);
    send(8'h10, 0);
    send(8'h00, 0);
    finish_checks(1);

    // start in DONE with a byte offered at the same time: the byte is not consumed.
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("done_start_ready", {63'd0, a_byte_ready}, 64'd1);
    chk("done_start_hold", {63'd0, a_core_hold}, 64'd1);
    chk("done_start_done", {63'd0, a_load_done}, 64'd0);
    img = '{32'h0042_8293, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    send_image(img, 1, 0);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
